// File: rtl/vga_fill_controller.sv
// Rectangular solid-colour fill engine for the VGA line buffer, sharing the
// buffer write port with the CPU register path (CPU always has priority).
module vga_fill_controller #(
  parameter  int unsigned BUFFER_SIZE = 2**16,
  localparam int unsigned AW          = $clog2(BUFFER_SIZE),
  localparam int unsigned DW          = 10,
  localparam int unsigned PW          = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_start_i,
  input  logic          cfg_abort_i,
  input  logic [AW-1:0] cfg_base_i,
  input  logic [DW-1:0] cfg_width_i,
  input  logic [DW-1:0] cfg_height_i,
  input  logic [DW-1:0] cfg_stride_i,
  input  logic [PW-1:0] cfg_pixel_i,
  input  logic          cpu_write_i,
  input  logic [AW-1:0] cpu_address_i,
  input  logic [PW-1:0] cpu_pixel_i,
  output logic          cpu_ready_o,
  input  logic          buf_ready_i,
  output logic          buf_write_o,
  output logic [AW-1:0] buf_address_o,
  output logic [PW-1:0] buf_pixel_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          start_error_o
);

  typedef logic [PW-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] row_base_q;
  logic [DW-1:0] x_q, y_q;
  logic [DW-1:0] width_q, height_q, stride_q;
  pixel_t        colour_q;
  logic          start_error_q;
  logic          fill_fire;
  logic          last_pixel;
  logic          zero_size;

  assign last_pixel  = (x_q == width_q - DW'(1)) && (y_q == height_q - DW'(1));
  assign zero_size   = (cfg_width_i == '0) || (cfg_height_i == '0);
  assign cpu_ready_o = buf_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort beats both completion and a colliding start
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cfg_start_i) state_d = zero_size ? DONE : FILL;
      FILL: begin
        if (cfg_abort_i)                  state_d = IDLE;
        else if (fill_fire && last_pixel) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-port arbitration and status decode
  always_comb begin
    buf_write_o   = 1'b0;
    buf_address_o = cpu_address_i;
    buf_pixel_o   = cpu_pixel_i;
    fill_fire     = 1'b0;
    busy_o        = (state_q == FILL);
    done_o        = (state_q == DONE);
    if (buf_ready_i) begin
      if (cpu_write_i) begin
        buf_write_o = 1'b1;
      end else if (state_q == FILL && !cfg_abort_i) begin
        buf_write_o   = 1'b1;
        buf_address_o = row_base_q + AW'(x_q);
        buf_pixel_o   = colour_q;
        fill_fire     = 1'b1;
      end
    end
  end

  // Fill configuration and raster position
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_base_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      width_q    <= '0;
      height_q   <= '0;
      stride_q   <= '0;
      colour_q   <= '0;
    end else if (state_q == IDLE && cfg_start_i) begin
      row_base_q <= cfg_base_i;
      x_q        <= '0;
      y_q        <= '0;
      width_q    <= cfg_width_i;
      height_q   <= cfg_height_i;
      stride_q   <= cfg_stride_i;
      colour_q   <= cfg_pixel_i;
    end else if (fill_fire) begin
      if (x_q == width_q - DW'(1)) begin
        x_q        <= '0;
        y_q        <= y_q + DW'(1);
        row_base_q <= row_base_q + AW'(stride_q);
      end else begin
        x_q <= x_q + DW'(1);
      end
    end
  end

  // A start outside IDLE is dropped and flagged one cycle later
  always_ff @(posedge clk_i) begin
    if (rst_i) start_error_q <= 1'b0;
    else       start_error_q <= cfg_start_i && (state_q != IDLE);
  end

  assign start_error_o = start_error_q;

endmodule

// File: tb/tb_vga_fill_controller.sv
// Self-checking bench for vga_fill_controller: directed scenarios plus random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_vga_fill_controller;

  localparam int unsigned AW = 16;

  logic          clk_i = 1'b0;
  logic          d_rst, d_start, d_abort, d_cpu_w, d_ready;
  logic [AW-1:0] d_base, d_cpu_a;
  logic [9:0]    d_w, d_h, d_stride;
  logic [11:0]   d_col, d_cpu_p;

  logic          cpu_ready, buf_write, busy, done, start_error;
  logic [AW-1:0] buf_address;
  logic [11:0]   buf_pixel;

  vga_fill_controller dut (
    .clk_i         (clk_i),
    .rst_i         (d_rst),
    .cfg_start_i   (d_start),
    .cfg_abort_i   (d_abort),
    .cfg_base_i    (d_base),
    .cfg_width_i   (d_w),
    .cfg_height_i  (d_h),
    .cfg_stride_i  (d_stride),
    .cfg_pixel_i   (d_col),
    .cpu_write_i   (d_cpu_w),
    .cpu_address_i (d_cpu_a),
    .cpu_pixel_i   (d_cpu_p),
    .cpu_ready_o   (cpu_ready),
    .buf_ready_i   (d_ready),
    .buf_write_o   (buf_write),
    .buf_address_o (buf_address),
    .buf_pixel_o   (buf_pixel),
    .busy_o        (busy),
    .done_o        (done),
    .start_error_o (start_error)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_done_cyc = -1;
  int fill_writes = 0;
  int cpu_writes = 0;

  // Reference model: remaining fill addresses in raster order
  int          m_q[$];
  logic [11:0] m_col;
  bit          m_active, m_done, m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_done   = 0;
    m_err    = 0;
  endtask

  // Check outputs ahead of the edge, then advance the model across it
  task automatic cycle();
    bit e_wr, e_fill, n_done, n_err;
    #2;
    e_fill = d_ready && !d_cpu_w && m_active && !d_abort;
    e_wr   = (d_ready && d_cpu_w) || e_fill;
    check_eq("cpu_ready", 32'(cpu_ready), 32'(d_ready));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("start_error", 32'(start_error), 32'(m_err));
    check_eq("buf_write", 32'(buf_write), 32'(e_wr));
    if (e_wr && !e_fill) begin
      check_eq("cpu_addr", 32'(buf_address), 32'(d_cpu_a));
      check_eq("cpu_pix", 32'(buf_pixel), 32'(d_cpu_p));
    end else if (e_fill) begin
      check_eq("fill_addr", 32'(buf_address), 32'(m_q[0]));
      check_eq("fill_pix", 32'(buf_pixel), 32'(m_col));
    end
    if (buf_write === 1'b1 && d_cpu_w) cpu_writes++;
    if (buf_write === 1'b1 && !d_cpu_w) fill_writes++;
    if (done === 1'b1) last_done_cyc = cyc;

    if (d_rst) begin
      model_reset();
    end else begin
      n_err  = d_start && (m_active || m_done);
      n_done = 0;
      if (m_active) begin
        if (d_abort) begin
          m_active = 0;
          m_q.delete();
        end else if (e_fill) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_active = 0;
            n_done   = 1;
          end
        end
      end else if (!m_done && d_start) begin
        m_q.delete();
        for (int yy = 0; yy < int'(d_h); yy++)
          for (int xx = 0; xx < int'(d_w); xx++)
            m_q.push_back((int'(d_base) + yy * int'(d_stride) + xx) & 32'hFFFF);
        m_col = d_col;
        if (m_q.size() == 0) n_done = 1;
        else m_active = 1;
      end
      m_done = n_done;
      m_err  = n_err;
    end
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic set_idle();
    d_rst = 0; d_start = 0; d_abort = 0; d_cpu_w = 0; d_ready = 1;
    d_base = '0; d_w = '0; d_h = '0; d_stride = '0; d_col = '0;
    d_cpu_a = '0; d_cpu_p = '0;
  endtask

  task automatic start_fill(input int base, input int w, input int h, input int stride, input int col);
    d_start = 1; d_base = AW'(base); d_w = 10'(w); d_h = 10'(h);
    d_stride = 10'(stride); d_col = 12'(col);
    cycle();
    d_start = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int s, fw0, cw0;
  bit cpu_pend;

  initial begin
    set_idle();
    d_rst = 1;
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    model_reset();
    cycle();                                   // reset state, rst still high
    d_rst = 0;
    run(2);

    // 1) basic 3x2 fill
    s = cyc; fw0 = fill_writes;
    start_fill(100, 3, 2, 320, 12'hABC);
    run(8);
    check_eq("t1_done_lat", 32'(last_done_cyc - s), 32'd7);
    check_eq("t1_writes", 32'(fill_writes - fw0), 32'd6);

    // 2) CPU steals cycles 2-3
    s = cyc; cw0 = cpu_writes;
    start_fill(100, 3, 2, 320, 12'hABC);
    for (int k = 1; k < 12; k++) begin
      d_cpu_w = (k == 2 || k == 3); d_cpu_a = 16'd5; d_cpu_p = 12'h123;
      cycle();
    end
    d_cpu_w = 0;
    check_eq("t2_done_lat", 32'(last_done_cyc - s), 32'd9);
    check_eq("t2_cpu_writes", 32'(cpu_writes - cw0), 32'd2);

    // 3) address wrap
    s = cyc;
    start_fill(65535, 2, 1, 7, 12'h0F0);
    run(4);
    check_eq("t3_done_lat", 32'(last_done_cyc - s), 32'd3);

    // 4) zero-size fill
    s = cyc; fw0 = fill_writes;
    start_fill(10, 0, 5, 1, 12'h111);
    run(3);
    check_eq("t4_done_lat", 32'(last_done_cyc - s), 32'd1);
    check_eq("t4_writes", 32'(fill_writes - fw0), 32'd0);

    // 5) abort after 15 writes, then restart
    fw0 = fill_writes; s = last_done_cyc;
    start_fill(2000, 10, 10, 640, 12'h555);
    run(15);
    d_abort = 1; cycle(); d_abort = 0;
    run(3);
    check_eq("t5_writes", 32'(fill_writes - fw0), 32'd15);
    check_eq("t5_no_done", 32'(last_done_cyc), 32'(s));
    start_fill(3000, 2, 2, 5, 12'h777);
    run(6);

    // 6) start during FILL, start+abort together, reset mid-fill
    start_fill(400, 4, 3, 50, 12'h9A9);
    run(3);
    start_fill(9, 9, 9, 9, 12'hFFF);
    run(4);
    d_start = 1; d_abort = 1; cycle(); d_start = 0; d_abort = 0;
    run(2);
    start_fill(500, 5, 5, 20, 12'h321);
    run(4);
    d_rst = 1; cycle(); d_rst = 0;
    fw0 = fill_writes;
    run(3);
    check_eq("t6_rst_writes", 32'(fill_writes - fw0), 32'd0);

    // Random traffic; a CPU request holds until accepted
    cpu_pend = 0;
    for (int i = 0; i < 3000; i++) begin
      d_ready = ($urandom % 4) != 0;
      if (!cpu_pend) begin
        d_cpu_w = ($urandom % 5) == 0;
        d_cpu_a = AW'($urandom);
        d_cpu_p = 12'($urandom);
      end
      d_start = ($urandom % 20) == 0;
      d_base = AW'($urandom); d_w = 10'($urandom_range(0, 5));
      d_h = 10'($urandom_range(0, 5)); d_stride = 10'($urandom);
      d_col = 12'($urandom);
      d_abort = ($urandom % 60) == 0;
      d_rst = ($urandom % 500) == 0;
      cpu_pend = d_cpu_w && !d_ready;
      cycle();
    end
    set_idle();
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
